// File: rtl/cell_mem_arbiter.sv
// Arbitrates the single-port cell-state RAM between VGA scan-out (one-word cache),
// the evolution engine and the manual-edit read-modify-write toggler.
module cell_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int BIT_W      = 5,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              evo_req,
  input  logic              evo_we,
  input  logic [ADDR_W-1:0] evo_addr,
  input  logic [DATA_W-1:0] evo_wdata,
  output logic              evo_gnt,
  output logic              evo_rvalid,
  output logic [DATA_W-1:0] evo_rdata,
  input  logic              edit_req,
  input  logic [ADDR_W-1:0] edit_addr,
  input  logic [BIT_W-1:0]  edit_bit,
  output logic              edit_busy,
  output logic              edit_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {SRC_NONE, SRC_VGA, SRC_EVO, SRC_EDIT} src_e;
  typedef enum logic [1:0] {ED_IDLE, ED_RD, ED_WAIT, ED_WR} ed_e;

  src_e              tag_q, tag_d, src;
  logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
  logic              cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic [DATA_W-1:0] cache_data_q, cache_data_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  ed_e               ed_state_q, ed_state_d;
  logic [ADDR_W-1:0] ed_addr_q, ed_addr_d;
  logic [BIT_W-1:0]  ed_bit_q, ed_bit_d;
  logic [DATA_W-1:0] ed_word_q, ed_word_d;

  logic vga_miss, ed_acc, evo_hazard, evo_ok;

  // Slot arbitration; nothing is granted while reset is held so the RAM port stays idle.
  always_comb begin
    vga_miss   = (!cache_valid_q || (cache_addr_q != vga_addr)) &&
                 !((tag_q == SRC_VGA) && (tag_addr_q == vga_addr));
    ed_acc     = (ed_state_q == ED_RD) || (ed_state_q == ED_WR);
    evo_hazard = evo_we && ((ed_state_q == ED_WAIT) || (ed_state_q == ED_WR)) &&
                 (evo_addr == ed_addr_q);
    evo_ok     = evo_req && !evo_hazard;
    src        = SRC_NONE;
    if (!rst_n)                                src = SRC_NONE;
    else if (vga_miss)                         src = SRC_VGA;
    else if ((starve_q == STARVE_LIM) && evo_ok) src = SRC_EVO;
    else if (ed_acc)                           src = SRC_EDIT;
    else if (evo_ok)                           src = SRC_EVO;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (src)
      SRC_VGA: begin
        mem_en   = 1'b1;
        mem_addr = vga_addr;
      end
      SRC_EVO: begin
        mem_en    = 1'b1;
        mem_we    = evo_we;
        mem_addr  = evo_addr;
        mem_wdata = evo_we ? evo_wdata : '0;
      end
      SRC_EDIT: begin
        mem_en    = 1'b1;
        mem_we    = (ed_state_q == ED_WR);
        mem_addr  = ed_addr_q;
        mem_wdata = (ed_state_q == ED_WR) ? ed_word_q : '0;
      end
      default: ;
    endcase
  end

  assign evo_gnt    = (src == SRC_EVO);
  assign edit_done  = (src == SRC_EDIT) && (ed_state_q == ED_WR);
  assign edit_busy  = (ed_state_q != ED_IDLE);
  assign evo_rvalid = (tag_q == SRC_EVO);
  assign evo_rdata  = evo_rvalid ? mem_rdata : '0;
  assign vga_valid  = cache_valid_q && (cache_addr_q == vga_addr);
  assign vga_data   = cache_data_q;

  always_comb begin
    tag_d      = SRC_NONE;
    tag_addr_d = mem_addr;
    if (src == SRC_VGA)                                 tag_d = SRC_VGA;
    else if ((src == SRC_EVO) && !evo_we)               tag_d = SRC_EVO;
    else if ((src == SRC_EDIT) && (ed_state_q == ED_RD)) tag_d = SRC_EDIT;

    starve_d = starve_q;
    if (evo_gnt)                                 starve_d = '0;
    else if (evo_req && (starve_q != STARVE_LIM)) starve_d = starve_q + 1'b1;

    // Return loads first, then a same-cycle write to the (new) cached address kills it.
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;
    if (tag_q == SRC_VGA) begin
      cache_valid_d = 1'b1;
      cache_addr_d  = tag_addr_q;
      cache_data_d  = mem_rdata;
    end
    if (mem_we && (mem_addr == cache_addr_d)) cache_valid_d = 1'b0;

    ed_state_d = ed_state_q;
    ed_addr_d  = ed_addr_q;
    ed_bit_d   = ed_bit_q;
    ed_word_d  = ed_word_q;
    case (ed_state_q)
      ED_IDLE: if (edit_req) begin
        ed_addr_d  = edit_addr;
        ed_bit_d   = edit_bit;
        ed_state_d = ED_RD;
      end
      ED_RD:   if (src == SRC_EDIT) ed_state_d = ED_WAIT;
      ED_WAIT: begin
        ed_word_d  = mem_rdata ^ ({{(DATA_W-1){1'b0}}, 1'b1} << ed_bit_q);
        ed_state_d = ED_WR;
      end
      ED_WR:   if (src == SRC_EDIT) ed_state_d = ED_IDLE;
      default: ed_state_d = ED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q         <= SRC_NONE;
      tag_addr_q    <= '0;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
      starve_q      <= '0;
      ed_state_q    <= ED_IDLE;
      ed_addr_q     <= '0;
      ed_bit_q      <= '0;
      ed_word_q     <= '0;
    end else begin
      tag_q         <= tag_d;
      tag_addr_q    <= tag_addr_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
      starve_q      <= starve_d;
      ed_state_q    <= ed_state_d;
      ed_addr_q     <= ed_addr_d;
      ed_bit_q      <= ed_bit_d;
      ed_word_q     <= ed_word_d;
    end
  end

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Directed bench for cell_mem_arbiter with a small synchronous RAM model behind it.
module tb_cell_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] vga_addr;
  logic [31:0] vga_data;
  logic        vga_valid;
  logic        evo_req, evo_we;
  logic [15:0] evo_addr;
  logic [31:0] evo_wdata;
  logic        evo_gnt, evo_rvalid;
  logic [31:0] evo_rdata;
  logic        edit_req;
  logic [15:0] edit_addr;
  logic [4:0]  edit_bit;
  logic        edit_busy, edit_done;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        ram_init;
  logic [31:0] ram [64];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          rd_cnt  = 0;

  cell_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .BIT_W(5), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .evo_req(evo_req), .evo_we(evo_we), .evo_addr(evo_addr), .evo_wdata(evo_wdata),
    .evo_gnt(evo_gnt), .evo_rvalid(evo_rvalid), .evo_rdata(evo_rdata),
    .edit_req(edit_req), .edit_addr(edit_addr), .edit_bit(edit_bit),
    .edit_busy(edit_busy), .edit_done(edit_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input int i);
    if (i == 5) return 32'h0000_00F0;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= seed(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  always @(negedge clk) if (rst_n && mem_en && !mem_we) rd_cnt++;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ram_init = 1'b1; vga_addr = 16'h0010;
    evo_req = 1'b0; evo_we = 1'b0; evo_addr = '0; evo_wdata = '0;
    edit_req = 1'b0; edit_addr = '0; edit_bit = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 50'd0) begin
      err_cnt++; $display("FAIL reset_mem: got en=%0b we=%0b addr=%h wd=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    vec_cnt++;
    if ({vga_valid, vga_data, evo_gnt, evo_rvalid, evo_rdata, edit_busy, edit_done} !== 69'd0) begin
      err_cnt++; $display("FAIL reset_outs: got vv=%0b vd=%h eg=%0b erv=%0b erd=%h eb=%0b ed=%0b want all 0",
                          vga_valid, vga_data, evo_gnt, evo_rvalid, evo_rdata, edit_busy, edit_done);
    end
  endtask

  task automatic test_vga_cache;
    int rd0;
    @(posedge clk); #1;
    ram_init = 1'b0; rst_n = 1'b1; rd0 = rd_cnt;
    @(negedge clk);
    vec_cnt++;
    if ({mem_en, mem_we, mem_addr, vga_valid} !== {1'b1, 1'b0, 16'h0010, 1'b0}) begin
      err_cnt++; $display("FAIL vga_miss_issue: got en=%0b we=%0b addr=%h vv=%0b want 1 0 0010 0", mem_en, mem_we, mem_addr, vga_valid);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({mem_en, vga_valid} !== 2'b00) begin
      err_cnt++; $display("FAIL vga_inflight: got en=%0b vv=%0b want 0 0", mem_en, vga_valid);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({vga_valid, vga_data} !== {1'b1, 32'hC0DE_0010}) begin
      err_cnt++; $display("FAIL vga_fill: got vv=%0b vd=%h want 1 c0de0010", vga_valid, vga_data);
    end
    repeat (38) tick();
    vec_cnt++;
    if (rd_cnt - rd0 !== 1) begin
      err_cnt++; $display("FAIL vga_one_read: got %0d reads want 1", rd_cnt - rd0);
    end
  endtask

  task automatic test_vga_priority;
    logic        prev_gnt = 1'b0;
    logic [15:0] prev_addr = '0;
    evo_req = 1'b1; evo_we = 1'b0;
    for (int k = 0; k < 96; k++) begin
      vga_addr = 16'(k / 32);
      evo_addr = 16'(32 + (k % 8));
      @(negedge clk);
      vec_cnt++;
      if (k % 32 == 0) begin
        if ({mem_en, mem_we, mem_addr, evo_gnt} !== {1'b1, 1'b0, vga_addr, 1'b0}) begin
          err_cnt++; $display("FAIL prio_vga k=%0d: got en=%0b we=%0b addr=%h gnt=%0b want vga read of %h, gnt 0",
                              k, mem_en, mem_we, mem_addr, evo_gnt, vga_addr);
        end
      end else begin
        if ({evo_gnt, mem_addr} !== {1'b1, evo_addr}) begin
          err_cnt++; $display("FAIL prio_evo k=%0d: got gnt=%0b addr=%h want 1 %h", k, evo_gnt, mem_addr, evo_addr);
        end
      end
      vec_cnt++;
      if (evo_rvalid !== prev_gnt || (prev_gnt && evo_rdata !== seed(int'(prev_addr)))) begin
        err_cnt++; $display("FAIL prio_rdata k=%0d: got rv=%0b rd=%h want rv=%0b rd=%h",
                            k, evo_rvalid, evo_rdata, prev_gnt, seed(int'(prev_addr)));
      end
      prev_gnt = evo_gnt; prev_addr = evo_addr;
      tick();
    end
    evo_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_edit_rmw;
    edit_req = 1'b1; edit_addr = 16'd5; edit_bit = 5'd4;
    @(negedge clk);
    vec_cnt++;
    if ({edit_busy, mem_en} !== 2'b00) begin
      err_cnt++; $display("FAIL edit_c0: got busy=%0b en=%0b want 0 0", edit_busy, mem_en);
    end
    tick(); edit_req = 1'b0; @(negedge clk);
    vec_cnt++;
    if ({edit_busy, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 16'd5}) begin
      err_cnt++; $display("FAIL edit_read: got busy=%0b en=%0b we=%0b addr=%h want 1 1 0 0005", edit_busy, mem_en, mem_we, mem_addr);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({edit_busy, mem_en} !== 2'b10) begin
      err_cnt++; $display("FAIL edit_wait: got busy=%0b en=%0b want 1 0", edit_busy, mem_en);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({edit_busy, edit_done, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1111, 16'd5, 32'h0000_00E0}) begin
      err_cnt++; $display("FAIL edit_write: got busy=%0b done=%0b en=%0b we=%0b addr=%h wd=%h want 1 1 1 1 0005 000000e0",
                          edit_busy, edit_done, mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({edit_busy, edit_done, ram[5]} !== {2'b00, 32'h0000_00E0}) begin
      err_cnt++; $display("FAIL edit_after: got busy=%0b done=%0b ram5=%h want 0 0 000000e0", edit_busy, edit_done, ram[5]);
    end
    tick();
  endtask

  task automatic test_starvation;
    evo_req = 1'b1; evo_we = 1'b0; evo_addr = 16'h0030;
    edit_req = 1'b1; edit_addr = 16'h0031; edit_bit = 5'd0;
    for (int k = 0; k < 8; k++) begin
      vga_addr = 16'(3 + k);
      @(negedge clk);
      vec_cnt++;
      if ({evo_gnt, mem_addr} !== {1'b0, vga_addr}) begin
        err_cnt++; $display("FAIL starve_deny k=%0d: got gnt=%0b addr=%h want 0 %h", k, evo_gnt, mem_addr, vga_addr);
      end
      tick();
      edit_req = 1'b0;
    end
    @(negedge clk);
    vec_cnt++;
    if ({evo_gnt, mem_addr, edit_busy} !== {1'b1, 16'h0030, 1'b1}) begin
      err_cnt++; $display("FAIL starve_win: got gnt=%0b addr=%h busy=%0b want 1 0030 1", evo_gnt, mem_addr, edit_busy);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({evo_gnt, mem_we, mem_addr, evo_rvalid, evo_rdata} !== {2'b00, 16'h0031, 1'b1, 32'hC0DE_0030}) begin
      err_cnt++; $display("FAIL starve_reset_cnt: got gnt=%0b we=%0b addr=%h rv=%0b rd=%h want 0 0 0031 1 c0de0030",
                          evo_gnt, mem_we, mem_addr, evo_rvalid, evo_rdata);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({evo_gnt, mem_addr} !== {1'b1, 16'h0030}) begin
      err_cnt++; $display("FAIL starve_wait_slot: got gnt=%0b addr=%h want 1 0030", evo_gnt, mem_addr);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({evo_gnt, edit_done, mem_we, mem_wdata} !== {3'b011, 32'hC0DE_0030}) begin
      err_cnt++; $display("FAIL starve_edit_wr: got gnt=%0b done=%0b we=%0b wd=%h want 0 1 1 c0de0030", evo_gnt, edit_done, mem_we, mem_wdata);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({evo_gnt, edit_busy} !== 2'b10) begin
      err_cnt++; $display("FAIL starve_end: got gnt=%0b busy=%0b want 1 0", evo_gnt, edit_busy);
    end
    tick(); evo_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_coherency;
    vga_addr = 16'd7;
    repeat (2) tick();
    @(negedge clk);
    vec_cnt++;
    if ({vga_valid, vga_data} !== {1'b1, 32'hC0DE_0007}) begin
      err_cnt++; $display("FAIL coh_fill7: got vv=%0b vd=%h want 1 c0de0007", vga_valid, vga_data);
    end
    tick(); evo_req = 1'b1; evo_we = 1'b1; evo_addr = 16'd7; evo_wdata = 32'h1234_5678;
    @(negedge clk);
    vec_cnt++;
    if ({evo_gnt, mem_we} !== 2'b11) begin
      err_cnt++; $display("FAIL coh_wr7: got gnt=%0b we=%0b want 1 1", evo_gnt, mem_we);
    end
    tick(); evo_req = 1'b0; evo_we = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({vga_valid, mem_en, mem_we, mem_addr} !== {3'b010, 16'd7}) begin
      err_cnt++; $display("FAIL coh_refetch7: got vv=%0b en=%0b we=%0b addr=%h want 0 1 0 0007", vga_valid, mem_en, mem_we, mem_addr);
    end
    repeat (2) tick();
    @(negedge clk);
    vec_cnt++;
    if ({vga_valid, vga_data} !== {1'b1, 32'h1234_5678}) begin
      err_cnt++; $display("FAIL coh_new7: got vv=%0b vd=%h want 1 12345678", vga_valid, vga_data);
    end
    tick(); vga_addr = 16'd8;
    @(negedge clk);
    vec_cnt++;
    if ({mem_en, mem_addr} !== {1'b1, 16'd8}) begin
      err_cnt++; $display("FAIL coh_miss8: got en=%0b addr=%h want 1 0008", mem_en, mem_addr);
    end
    tick(); evo_req = 1'b1; evo_we = 1'b1; evo_addr = 16'd8; evo_wdata = 32'h8765_4321;
    @(negedge clk);
    vec_cnt++;
    if ({evo_gnt, mem_we} !== 2'b11) begin
      err_cnt++; $display("FAIL coh_wr8_on_return: got gnt=%0b we=%0b want 1 1", evo_gnt, mem_we);
    end
    tick(); evo_req = 1'b0; evo_we = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({vga_valid, mem_en, mem_addr} !== {2'b01, 16'd8}) begin
      err_cnt++; $display("FAIL coh_refetch8: got vv=%0b en=%0b addr=%h want 0 1 0008", vga_valid, mem_en, mem_addr);
    end
    repeat (2) tick();
    @(negedge clk);
    vec_cnt++;
    if ({vga_valid, vga_data} !== {1'b1, 32'h8765_4321}) begin
      err_cnt++; $display("FAIL coh_new8: got vv=%0b vd=%h want 1 87654321", vga_valid, vga_data);
    end
    tick();
  endtask

  task automatic test_hazard;
    edit_req = 1'b1; edit_addr = 16'd9; edit_bit = 5'd3;
    tick(); edit_req = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'd9}) begin
      err_cnt++; $display("FAIL haz_rd: got en=%0b we=%0b addr=%h want 1 0 0009", mem_en, mem_we, mem_addr);
    end
    tick(); evo_req = 1'b1; evo_we = 1'b1; evo_addr = 16'd9; evo_wdata = 32'hAAAA_5555;
    @(negedge clk);
    vec_cnt++;
    if ({evo_gnt, mem_en} !== 2'b00) begin
      err_cnt++; $display("FAIL haz_wait_block: got gnt=%0b en=%0b want 0 0", evo_gnt, mem_en);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({evo_gnt, edit_done, mem_wdata} !== {2'b01, 32'hC0DE_0001}) begin
      err_cnt++; $display("FAIL haz_wr_block: got gnt=%0b done=%0b wd=%h want 0 1 c0de0001", evo_gnt, edit_done, mem_wdata);
    end
    tick(); @(negedge clk);
    vec_cnt++;
    if ({evo_gnt, mem_we, mem_addr, edit_busy} !== {2'b11, 16'd9, 1'b0}) begin
      err_cnt++; $display("FAIL haz_release: got gnt=%0b we=%0b addr=%h busy=%0b want 1 1 0009 0", evo_gnt, mem_we, mem_addr, edit_busy);
    end
    tick(); evo_req = 1'b0; evo_we = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (ram[9] !== 32'hAAAA_5555) begin
      err_cnt++; $display("FAIL haz_ram9: got %h want aaaa5555", ram[9]);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    edit_req = 1'b1; edit_addr = 16'h000B; edit_bit = 5'd2;
    tick(); edit_req = 1'b0;
    tick(); tick(); #1;
    vec_cnt++;
    if ({mem_we, edit_done} !== 2'b11) begin
      err_cnt++; $display("FAIL rstmid_in_wr: got we=%0b done=%0b want 1 1", mem_we, edit_done);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({edit_busy, edit_done, mem_en, mem_we, vga_valid, vga_data, evo_rvalid, evo_gnt} !== 38'd0) begin
      err_cnt++; $display("FAIL rstmid_outs: got busy=%0b done=%0b en=%0b we=%0b vv=%0b vd=%h rv=%0b gnt=%0b want all 0",
                          edit_busy, edit_done, mem_en, mem_we, vga_valid, vga_data, evo_rvalid, evo_gnt);
    end
    repeat (2) tick();
    vec_cnt++;
    if (ram[11] !== 32'hC0DE_000B) begin
      err_cnt++; $display("FAIL rstmid_ram: got %h want c0de000b", ram[11]);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    vec_cnt++;
    if ({vga_valid, vga_data, edit_busy} !== {1'b1, 32'h8765_4321, 1'b0}) begin
      err_cnt++; $display("FAIL rstmid_recover: got vv=%0b vd=%h busy=%0b want 1 87654321 0", vga_valid, vga_data, edit_busy);
    end
  endtask

  initial begin
    test_reset();
    test_vga_cache();
    test_vga_priority();
    test_edit_rmw();
    test_starvation();
    test_coherency();
    test_hazard();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cell_mem_arbiter.md
Name: cell_mem_arbiter

Overview:
- Shares the single-port cell-state RAM (one DATA_W-bit word per memory address) between three requesters:
  - the VGA scan-out reader,
  - the evolution engine (bulk read/write),
  - the manual-edit cell toggler.
- VGA reads are real-time and never delayed. A one-word VGA cache cuts RAM traffic to one read per word change.
- Manual edits run as an internal read-modify-write (RMW) that flips one bit.
- The block sits between the display/engine/edit logic and the block RAM.

Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 32, word width (cells per word); must be a power of 2.
- BIT_W, 5, log2(DATA_W); selects the bit to toggle.
- STARVE_MAX, 8, consecutive evo denials before evo beats edit for one slot.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- vga_addr  in  ADDR_W  word address the scan-out currently needs (may repeat every cycle).
- vga_data  out  DATA_W  cached word for vga_addr.
- vga_valid  out  1  vga_data corresponds to the current vga_addr.
- evo_req  in  1  engine access request.
- evo_we  in  1  1 = write, 0 = read.
- evo_addr  in  ADDR_W  engine address.
- evo_wdata  in  DATA_W  engine write data.
- evo_gnt  out  1  combinational; request accepted this cycle.
- evo_rvalid  out  1  read data valid (one cycle after a read grant).
- evo_rdata  out  DATA_W  read data.
- edit_req  in  1  toggle request; sampled only when edit_busy=0.
- edit_addr  in  ADDR_W  word address of the cell.
- edit_bit  in  BIT_W  bit index within the word.
- edit_busy  out  1  RMW in progress.
- edit_done  out  1  one-cycle pulse when the write-back is issued.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; synchronous, 1-cycle latency.

Behaviour:
- Reset state: all outputs 0; cache invalid; edit FSM IDLE; starvation counter 0; return tag NONE.
- RAM slot arbitration: one access per cycle, decided combinationally. mem_* outputs are driven in the grant cycle.
- Priority order each cycle:
  1. VGA miss: vga_addr != cached_addr, or cache invalid, and no VGA read already in flight for vga_addr.
  2. Edit FSM access in ED_RD or ED_WR.
  3. evo_req.
- Exception to the order: if the starvation counter == STARVE_MAX, evo beats edit (never VGA).
- Starvation counter: +1 on each cycle evo_req=1 and evo_gnt=0, saturating at STARVE_MAX; cleared on evo_gnt.
- Return tag: a 1-cycle register (NONE/VGA/EVO/EDIT) that routes mem_rdata in the following cycle.
- VGA timing: miss issued in cycle t; cache word and cached_addr load at the end of t+1; vga_data and vga_valid are correct from cycle t+2.
- vga_valid is combinational: cache valid AND cached_addr == vga_addr.
- If vga_addr changes while a VGA read is in flight, a new read is issued for the new address; the stale return still loads the cache but never satisfies the new address.
- Coherency: any granted write (evo or edit) to cached_addr invalidates the cache, which forces a refetch. A write landing in the same cycle as a VGA return for that address also leaves the cache invalid.
- Evo read: evo_rvalid=1 in cycle t+1 with evo_rdata = mem_rdata.
- Evo write: completes in the grant cycle; no evo_rvalid.
- Edit FSM:
  - IDLE: on edit_req, latch addr and bit, go to ED_RD, assert edit_busy.
  - ED_RD: when granted, issue the read, go to ED_WAIT.
  - ED_WAIT: capture mem_rdata XOR (1 << bit), go to ED_WR.
  - ED_WR: when granted, write the word, pulse edit_done, go to IDLE.
  - edit_busy stays high from the cycle after the request through the ED_WR grant cycle.
- Hazard: while the FSM is in ED_WAIT or ED_WR, an evo write with evo_addr == latched edit addr is not granted. Evo reads to that address are allowed.
- edit_req while busy is ignored; the requester holds it until edit_busy=0.
- Reset mid-operation: FSM returns to IDLE and any pending write is dropped. A read in flight is discarded (tag cleared).

Test Plan:
- VGA caching: vga_addr=0x0010 held 40 cycles → exactly one mem_en read; vga_valid=1 from cycle 2; vga_data = RAM[0x10].
- VGA priority: evo_req continuous reads, vga_addr stepping 0,1,2 every 32 cycles → a VGA read is always granted on the change cycle; evo_gnt=0 in exactly those cycles; evo_rdata matches RAM for every evo read.
- Edit RMW: RAM[5]=0x0000_00F0, edit_addr=5, edit_bit=4 → read then write 0x0000_00E0; edit_done pulses once; edit_busy deasserts the next cycle.
- Starvation: edit_req issued back-to-back with STARVE_MAX=8 and evo_req held → evo granted within 9 cycles of its request; counter then returns to 0.
- Coherency and hazard:
  - VGA caching addr 7, evo writes RAM[7] → cache invalidated, refetch issued, new word visible.
  - Evo write to the latched edit address during ED_WAIT → evo_gnt=0 until edit_done.
- Reset: assert rst_n=0 while the FSM is in ED_WR → edit_busy=0, no mem_we; all outputs 0; RAM unchanged.
